// File: rtl/rca_seq.sv
// Sequential ripple-carry adder: one shared 4-bit slice adds one nibble per clock,
// LSB nibble first, producing {co,s} = a + b + ci after NIB RUN cycles.
module rca_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              ci,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  s,
    output logic              co
);

    localparam int unsigned W    = 4 * NIB;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [IdxW-1:0]   idx_q;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [4:0]        sum;
    logic              last;

    // The single 4-bit slice, fed by the nibble currently selected by idx_q.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        last = (idx_q == IdxW'(NIB - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            s[4*i +: 4] <= sum[3:0];
                        end
                    end
                    carry_q <= sum[4];
                    if (last) begin
                        co      <= sum[4];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq.sv
// Directed bench for rca_seq: NIB=4 scenarios plus an exhaustive NIB=1 instance.
module tb_rca_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        ci1;
    logic        busy1;
    logic        done1;
    logic [3:0]  s1;
    logic        co1;

    int n_checks;
    int n_fail;

    rca_seq #(.NIB(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    rca_seq #(.NIB(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then wait for done; cycles counts negedges after acceptance.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; ci = tci;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, co, s} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset4: got busy=%b done=%b co=%b s=%h required all zero",
                     busy, done, co, s);
        end
        n_checks++;
        if ({busy1, done1, co1, s1} !== 7'h0) begin
            n_fail++;
            $display("FAIL reset1: got busy=%b done=%b co=%b s=%h required all zero",
                     busy1, done1, co1, s1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; a = 16'h0001; b = 16'h000F; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            n_checks++;
            if (busy !== (j < 4)) begin
                n_fail++;
                $display("FAIL basic_busy j=%0d: got %b required %b", j, busy, (j < 4));
            end
            n_checks++;
            if (done !== (j == 4)) begin
                n_fail++;
                $display("FAIL basic_done j=%0d: got %b required %b", j, done, (j == 4));
            end
            if (j == 4) begin
                n_checks++;
                if (s !== 16'h0010 || co !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_sum: got co=%b s=%h required co=0 s=0010", co, s);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_carry_ripple();
        int cycles;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Nibble 0 written as 0; nibble 1 still holds the previous result's 1.
        n_checks++;
        if (s !== 16'h0010 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_partial: got co=%b s=%h required co=0 s=0010", co, s);
        end
        cycles = 1;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles !== 4) begin
            n_fail++;
            $display("FAIL ripple_latency: got %0d required 4", cycles);
        end
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_sum: got co=%b s=%h required co=1 s=0000", co, s);
        end
    endtask

    task automatic test_ignore_start();
        int cycles;
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h4321; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'h0000; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cycles = 2;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles !== 4) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d required 4", cycles);
        end
        n_checks++;
        if (s !== 16'h5556 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_sum: got co=%b s=%h required co=0 s=5556", co, s);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h5556) begin
            n_fail++;
            $display("FAIL ignore_after: got busy=%b done=%b s=%h required busy=0 done=0 s=5556",
                     busy, done, s);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        run_op(16'h1111, 16'h2222, 1'b0, cycles);
        n_checks++;
        if (cycles !== 4 || s !== 16'h3333 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got cycles=%0d co=%b s=%h required cycles=4 co=0 s=3333",
                     cycles, co, s);
        end
        // Still in the DONE cycle: request the next addition immediately.
        start = 1'b1; a = 16'h8000; b = 16'h8000; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b required busy=1 done=0", busy, done);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles !== 4) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d required 4", cycles);
        end
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_sum: got co=%b s=%h required co=1 s=0000", co, s);
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        int seen_done;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s !== 16'h000F) begin
            n_fail++;
            $display("FAIL rstmid_partial: got s=%h required 000F", s);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0000 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got busy=%b done=%b co=%b s=%h required all zero",
                     busy, done, co, s);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d active cycles required 0", seen_done);
        end
        run_op(16'h0003, 16'h0004, 1'b0, cycles);
        n_checks++;
        if (cycles !== 4 || s !== 16'h0007 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got cycles=%0d co=%b s=%h required cycles=4 co=0 s=0007",
                     cycles, co, s);
        end
    endtask

    task automatic test_exhaustive_nib1();
        int cycles;
        logic [4:0] expv;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    start1 = 1'b1; a1 = 4'(ai); b1 = 4'(bi); ci1 = c[0];
                    @(negedge clk);
                    start1 = 1'b0;
                    cycles = 0;
                    while (done1 !== 1'b1 && cycles < 10) begin
                        @(negedge clk);
                        cycles++;
                    end
                    expv = 5'(ai) + 5'(bi) + 5'(c);
                    n_checks++;
                    if ({co1, s1} !== expv || cycles !== 1) begin
                        n_fail++;
                        $display("FAIL nib1 a=%h b=%h ci=%0d: got %h after %0d required %h after 1",
                                 ai[3:0], bi[3:0], c, {co1, s1}, cycles, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b1;
        start  = 1'b0; a  = '0; b  = '0; ci  = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_nib1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
